// File: rtl/wdt_pkg.sv
// rtl/wdt_pkg.sv - shared types and constants for the watchdog and its reset sequencer
package wdt_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_WDT  = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_LOCK = 2'b11;

  // Timeout lengths selectable in the watchdog timer itself
  localparam int WDT_TIMEOUT_W       = 16;
  localparam int WDT_TIMEOUT_SHORT   = 1024;
  localparam int WDT_TIMEOUT_DEFAULT = 4096;
  localparam int WDT_TIMEOUT_LONG    = 65535;

endpackage

// File: rtl/rst_seq_counter.sv
// rtl/rst_seq_counter.sv - phase counter with synchronous clear and terminal-count compare
module rst_seq_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && (count == limit);

endmodule

// File: rtl/wdt_reset_sequencer.sv
// rtl/wdt_reset_sequencer.sv - stretches watchdog/software resets, records cause, escalates to lockout
module wdt_reset_sequencer
  import wdt_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_BITES     = 3,
  parameter int CNT_W         = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wdt_bite,
  input  logic                             sw_rst_req,
  input  logic                             cause_clr,
  output logic                             sys_rst_n,
  output logic                             wd_en_o,
  output logic [1:0]                       rst_cause,
  output logic [$clog2(MAX_BITES+1)-1:0]   bite_count,
  output logic                             locked
);

  localparam int BW = $clog2(MAX_BITES + 1);

  state_t           state;
  logic             bite_d;
  logic             bite_edge;
  logic             last_bite;
  logic             cnt_en;
  logic             cnt_clr;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_limit;

  assign bite_edge = wdt_bite & ~bite_d;
  assign last_bite = (32'(bite_count) + 32'd1) == 32'(MAX_BITES);

  // One counter serves both timed phases; it idles at zero outside them
  assign cnt_en    = (state == ASSERT) || (state == RELEASE);
  assign cnt_clr   = cnt_tc || !cnt_en;
  assign cnt_limit = (state == ASSERT) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(SETTLE_CYCLES - 1);

  rst_seq_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_limit),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ASSERT;
      sys_rst_n  <= 1'b0;
      wd_en_o    <= 1'b0;
      rst_cause  <= CAUSE_POR;
      bite_count <= '0;
      locked     <= 1'b0;
      bite_d     <= 1'b0;
    end else begin
      bite_d <= wdt_bite;
      case (state)
        ASSERT: begin
          if (cnt_tc) begin
            state     <= RELEASE;
            sys_rst_n <= 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_tc) begin
            state   <= RUN;
            wd_en_o <= 1'b1;
          end
        end
        RUN: begin
          if (bite_edge) begin
            sys_rst_n <= 1'b0;
            wd_en_o   <= 1'b0;
            if (last_bite) begin
              state      <= LOCKED;
              rst_cause  <= CAUSE_LOCK;
              bite_count <= BW'(MAX_BITES);
              locked     <= 1'b1;
            end else begin
              state      <= ASSERT;
              rst_cause  <= CAUSE_WDT;
              bite_count <= bite_count + 1'b1;
            end
          end else if (sw_rst_req) begin
            state     <= ASSERT;
            sys_rst_n <= 1'b0;
            wd_en_o   <= 1'b0;
            rst_cause <= CAUSE_SW;
          end else if (cause_clr) begin
            bite_count <= '0;
          end
        end
        LOCKED: begin
          sys_rst_n <= 1'b0;
          wd_en_o   <= 1'b0;
          locked    <= 1'b1;
        end
        default: state <= ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_wdt_reset_sequencer.sv
// tb/tb_wdt_reset_sequencer.sv - directed self-checking bench for wdt_reset_sequencer
module tb_wdt_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wdt_bite = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       cause_clr = 1'b0;
  logic       sys_rst_n;
  logic       wd_en_o;
  logic [1:0] rst_cause;
  logic [1:0] bite_count;
  logic       locked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wdt_reset_sequencer #(
    .HOLD_CYCLES   (16),
    .SETTLE_CYCLES (8),
    .MAX_BITES     (3),
    .CNT_W         (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wdt_bite   (wdt_bite),
    .sw_rst_req (sw_rst_req),
    .cause_clr  (cause_clr),
    .sys_rst_n  (sys_rst_n),
    .wd_en_o    (wd_en_o),
    .rst_cause  (rst_cause),
    .bite_count (bite_count),
    .locked     (locked)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic r, input logic w, input logic [1:0] c,
                           input logic [1:0] b, input logic l);
    chk({tag, ".sys_rst_n"}, sys_rst_n, r);
    chk({tag, ".wd_en_o"}, wd_en_o, w);
    chk({tag, ".rst_cause"}, rst_cause, c);
    chk({tag, ".bite_count"}, bite_count, b);
    chk({tag, ".locked"}, locked, l);
  endtask

  // Counts posedges until reset releases, then until the watchdog is re-enabled
  task automatic run_seq(input string tag, input int exp_hold, input int exp_settle);
    int n;
    n = 0;
    do begin tick(); n++; end while (!sys_rst_n && n < 200);
    chk({tag, ".hold_len"}, n, exp_hold);
    chk({tag, ".wd_off_release"}, wd_en_o, 0);
    n = 0;
    do begin tick(); n++; end while (!wd_en_o && n < 200);
    chk({tag, ".settle_len"}, n, exp_settle);
    chk({tag, ".run_rst_high"}, sys_rst_n, 1);
  endtask

  task automatic pulse_bite();
    wdt_bite = 1'b1;
    tick();
    wdt_bite = 1'b0;
  endtask

  task automatic pulse_clr();
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout sim did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Power-on reset
    repeat (3) tick();
    chk_state("por_in_reset", 0, 0, 2'b00, 2'd0, 0);
    rst = 1'b1;
    run_seq("por", 16, 8);
    chk_state("por_run", 1, 1, 2'b00, 2'd0, 0);

    // 2. Single bite
    pulse_bite();
    chk_state("bite1", 0, 0, 2'b01, 2'd1, 0);
    run_seq("bite1", 16, 8);

    // 3. Escalation to lockout
    pulse_clr();
    chk_state("clr_in_run", 1, 1, 2'b01, 2'd0, 0);
    pulse_bite();
    chk("esc1.count", bite_count, 1);
    run_seq("esc1", 16, 8);
    pulse_bite();
    chk("esc2.count", bite_count, 2);
    run_seq("esc2", 16, 8);
    pulse_bite();
    chk_state("esc3_locked", 0, 0, 2'b11, 2'd3, 1);
    for (int i = 0; i < 120; i++) begin
      sw_rst_req = i[3];
      cause_clr  = i[2];
      wdt_bite   = i[1];
      tick();
    end
    sw_rst_req = 1'b0;
    cause_clr  = 1'b0;
    wdt_bite   = 1'b0;
    chk_state("locked_hold", 0, 0, 2'b11, 2'd3, 1);
    rst = 1'b0;
    #1;
    chk_state("unlock_rst", 0, 0, 2'b00, 2'd0, 0);
    tick();
    tick();
    rst = 1'b1;
    run_seq("unlock_por", 16, 8);
    chk_state("unlock_run", 1, 1, 2'b00, 2'd0, 0);

    // 4. Clear between bites
    pulse_bite();
    chk("clrb.b1", bite_count, 1);
    run_seq("clrb1", 16, 8);
    pulse_clr();
    chk("clrb.clr", bite_count, 0);
    pulse_bite();
    chk("clrb.b2", bite_count, 1);
    run_seq("clrb2", 16, 8);
    pulse_bite();
    chk("clrb.b3", bite_count, 2);
    chk("clrb.not_locked", locked, 0);
    run_seq("clrb3", 16, 8);
    pulse_clr();
    chk("clrb.clr2", bite_count, 0);

    // 5. Simultaneous bite and software request; held bite level
    wdt_bite   = 1'b1;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk_state("simul", 0, 0, 2'b01, 2'd1, 0);
    pulse_clr();
    chk("clr_ignored_assert", bite_count, 1);
    run_seq("simul", 15, 8);
    repeat (10) tick();
    chk("held_bite.no_reset", sys_rst_n, 1);
    chk("held_bite.count", bite_count, 1);
    wdt_bite = 1'b0;
    tick();
    wdt_bite = 1'b1;
    tick();
    wdt_bite = 1'b0;
    chk_state("rebite", 0, 0, 2'b01, 2'd2, 0);
    run_seq("rebite", 16, 8);
    sw_rst_req = 1'b1;
    cause_clr  = 1'b1;
    tick();
    cause_clr  = 1'b0;
    chk_state("sw_over_clr", 0, 0, 2'b10, 2'd2, 0);
    run_seq("sw_held", 16, 8);
    tick();
    chk("sw_held.retrigger", sys_rst_n, 0);
    chk("sw_held.cause", rst_cause, 2'b10);
    sw_rst_req = 1'b0;
    run_seq("sw_retrig", 16, 8);

    // 6. Reset during RELEASE
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (16) tick();
    repeat (3) tick();
    chk("mid.release_rst", sys_rst_n, 1);
    chk("mid.release_wd", wd_en_o, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_state("mid_abort", 0, 0, 2'b00, 2'd0, 0);
    tick();
    tick();
    rst = 1'b1;
    run_seq("mid_restart", 16, 8);
    chk_state("mid_run", 1, 1, 2'b00, 2'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
